// File: rtl/param_stack.sv
// -----------------------------------------------------------------------------
// param_stack
//   Parametrised LIFO stack used as the path/move store beside the maze
//   controller; usable wherever LIFO buffering is needed.
//
// Parameters
//   WIDTH  data word width in bits (>=1)
//   DEPTH  number of entries, power of two, >=2
//   AW     derived pointer index width, $clog2(DEPTH)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   init       synchronous clear of pointer, data_out and error flags
//   push       push request
//   pop        pop request (push+pop together = replace top)
//   data_in    word to push
//   data_out   registered word removed by the most recent successful pop
//   top        combinational peek of the top entry, 0 when empty
//   count      occupancy 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   push rejected because the stack was full
//   underflow  pop rejected because the stack was empty
//
// Build option
//   PARAM_STACK_STICKY_ERR_EN  defined: overflow/underflow are sticky until
//                              rst or init. Undefined: they pulse for one
//                              cycle after the rejecting edge.
// -----------------------------------------------------------------------------
module param_stack #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] top,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  // Registered state
  logic [AW:0]      sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Memory write port, decided combinationally
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  // Error events of the current edge
  logic             ovf_evt;
  logic             unf_evt;

  logic             is_empty;
  logic             is_full;
  logic [AW-1:0]    top_idx;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SP_FULL);
  // sp-1 truncated to AW bits; when full (sp == DEPTH) this wraps to DEPTH-1,
  // which is exactly the top slot. Not used when empty.
  assign top_idx  = AW'(sp_q - SP_ONE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sp_d      = sp_q;
    dout_d    = dout_q;
    mem_we    = 1'b0;
    mem_waddr = top_idx;
    mem_wdata = data_in;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;

    if (init) begin
      sp_d   = '0;
      dout_d = '0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          if (!is_empty) begin
            // Replace: old top goes out, new word takes its slot, depth unchanged.
            dout_d    = mem_q[top_idx];
            mem_we    = 1'b1;
            mem_waddr = top_idx;
          end else begin
            // Pop half is rejected; push half still lands in slot 0.
            unf_evt   = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = '0;
            sp_d      = SP_ONE;
          end
        end
        2'b10: begin
          if (is_full) begin
            ovf_evt = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = sp_q[AW-1:0];
            sp_d      = sp_q + SP_ONE;
          end
        end
        2'b01: begin
          if (is_empty) begin
            unf_evt = 1'b1;
          end else begin
            dout_d = mem_q[top_idx];
            sp_d   = sp_q - SP_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Error flag next state
  always_comb begin
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (!init) begin
`ifdef PARAM_STACK_STICKY_ERR_EN
      ovf_d = ovf_q | ovf_evt;
      unf_d = unf_q | unf_evt;
`else
      ovf_d = ovf_evt;
      unf_d = unf_evt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers (async reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage is never cleared; writes are suppressed while reset is held so
  // a request pending during reset leaves no trace.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_out  = dout_q;
  assign top       = is_empty ? '0 : mem_q[top_idx];
  assign count     = sp_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

  logic clk = 1'b0;
  logic rst;

  // Small instance: WIDTH=2, DEPTH=4
  logic       init_s, push_s, pop_s;
  logic [1:0] din_s, dout_s, top_s;
  logic [2:0] cnt_s;
  logic       full_s, empty_s, ovf_s, unf_s;

  // Default-size instance: WIDTH=2, DEPTH=256
  logic       init_b, push_b, pop_b;
  logic [1:0] din_b, dout_b, top_b;
  logic [8:0] cnt_b;
  logic       full_b, empty_b, ovf_b, unf_b;

  int errors = 0;
  int checks = 0;

  param_stack #(.WIDTH(2), .DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .init(init_s), .push(push_s), .pop(pop_s),
    .data_in(din_s), .data_out(dout_s), .top(top_s), .count(cnt_s),
    .full(full_s), .empty(empty_s), .overflow(ovf_s), .underflow(unf_s)
  );

  param_stack #(.WIDTH(2), .DEPTH(256)) u_big (
    .clk(clk), .rst(rst), .init(init_b), .push(push_b), .pop(pop_b),
    .data_in(din_b), .data_out(dout_b), .top(top_b), .count(cnt_b),
    .full(full_b), .empty(empty_b), .overflow(ovf_b), .underflow(unf_b)
  );

  always #5 clk = ~clk;

  // Reference model: plain array + element count per instance
  logic [1:0] marr [2][256];
  int         mcnt  [2];
  int         mdep  [2];
  logic [1:0] mdout [2];
  logic       movf  [2];
  logic       munf  [2];

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d]  = 0;
      mdout[d] = 2'd0;
      movf[d]  = 1'b0;
      munf[d]  = 1'b0;
    end
  endtask

  task automatic mstep(input int d, input logic pu, input logic po,
                       input logic ini, input logic [1:0] di);
    logic eo;
    logic eu;
    eo = 1'b0;
    eu = 1'b0;
    if (ini) begin
      mcnt[d]  = 0;
      mdout[d] = 2'd0;
      movf[d]  = 1'b0;
      munf[d]  = 1'b0;
      return;
    end
    if (pu && po) begin
      if (mcnt[d] > 0) begin
        mdout[d] = marr[d][mcnt[d]-1];
        marr[d][mcnt[d]-1] = di;
      end else begin
        eu = 1'b1;
        marr[d][0] = di;
        mcnt[d] = 1;
      end
    end else if (pu) begin
      if (mcnt[d] == mdep[d]) eo = 1'b1;
      else begin
        marr[d][mcnt[d]] = di;
        mcnt[d]++;
      end
    end else if (po) begin
      if (mcnt[d] == 0) eu = 1'b1;
      else begin
        mcnt[d]--;
        mdout[d] = marr[d][mcnt[d]];
      end
    end
`ifdef PARAM_STACK_STICKY_ERR_EN
    movf[d] = movf[d] | eo;
    munf[d] = munf[d] | eu;
`else
    movf[d] = eo;
    munf[d] = eu;
`endif
  endtask

  function automatic logic [1:0] mtop(input int d);
    return (mcnt[d] > 0) ? marr[d][mcnt[d]-1] : 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/s.count"},     32'(cnt_s),   32'(mcnt[0]));
    chk({tag, "/s.top"},       32'(top_s),   32'(mtop(0)));
    chk({tag, "/s.full"},      32'(full_s),  32'(mcnt[0] == mdep[0]));
    chk({tag, "/s.empty"},     32'(empty_s), 32'(mcnt[0] == 0));
    chk({tag, "/s.data_out"},  32'(dout_s),  32'(mdout[0]));
    chk({tag, "/s.overflow"},  32'(ovf_s),   32'(movf[0]));
    chk({tag, "/s.underflow"}, 32'(unf_s),   32'(munf[0]));
    chk({tag, "/b.count"},     32'(cnt_b),   32'(mcnt[1]));
    chk({tag, "/b.top"},       32'(top_b),   32'(mtop(1)));
    chk({tag, "/b.full"},      32'(full_b),  32'(mcnt[1] == mdep[1]));
    chk({tag, "/b.empty"},     32'(empty_b), 32'(mcnt[1] == 0));
    chk({tag, "/b.data_out"},  32'(dout_b),  32'(mdout[1]));
    chk({tag, "/b.overflow"},  32'(ovf_b),   32'(movf[1]));
    chk({tag, "/b.underflow"}, 32'(unf_b),   32'(munf[1]));
  endtask

  task automatic idle_inputs();
    {init_s, push_s, pop_s, din_s} = '0;
    {init_b, push_b, pop_b, din_b} = '0;
  endtask

  // One clock edge: d selects the instance receiving the request, the other idles.
  task automatic step(input int d, input logic pu, input logic po,
                      input logic ini, input logic [1:0] di, input string tag);
    @(negedge clk);
    idle_inputs();
    if (d == 0) begin
      push_s = pu; pop_s = po; init_s = ini; din_s = di;
    end else begin
      push_b = pu; pop_b = po; init_b = ini; din_b = di;
    end
    @(posedge clk);
    #1;
    mstep(0, (d == 0) && pu, (d == 0) && po, (d == 0) && ini, di);
    mstep(1, (d == 1) && pu, (d == 1) && po, (d == 1) && ini, di);
    check_all(tag);
  endtask

  initial begin
    logic [1:0] r;
    mdep[0] = 4;
    mdep[1] = 256;
    idle_inputs();

    // Reset is visible immediately, without a clock edge
    rst = 1'b1;
    #1;
    mreset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mstep(0, 1'b0, 1'b0, 1'b0, 2'd0);
    mstep(1, 1'b0, 1'b0, 1'b0, 2'd0);
    check_all("post_reset");
    step(0, 1'b0, 1'b0, 1'b1, 2'd0, "init");

    // Ordered LIFO
    step(0, 1'b1, 1'b0, 1'b0, 2'd3, "push3");
    step(0, 1'b1, 1'b0, 1'b0, 2'd0, "push0");
    step(0, 1'b1, 1'b0, 1'b0, 2'd1, "push1");
    step(0, 1'b1, 1'b0, 1'b0, 2'd2, "push2_full");
    for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, 1'b0, 2'd0, "pop");
    step(0, 1'b0, 1'b1, 1'b0, 2'd0, "pop_underflow");
    step(0, 1'b0, 1'b0, 1'b0, 2'd0, "idle_after_underflow");

    // Overflow, then flag behaviour across an idle edge, replace while full
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1'b0, 2'(i + 1), "fill");
    step(0, 1'b1, 1'b0, 1'b0, 2'd1, "push_overflow");
    step(0, 1'b0, 1'b0, 1'b0, 2'd0, "idle_after_overflow");
    step(0, 1'b1, 1'b1, 1'b0, 2'd3, "replace_full");
    step(0, 1'b0, 1'b0, 1'b1, 2'd0, "init_clears_flags");

    // Replace with [3,0]
    step(0, 1'b1, 1'b0, 1'b0, 2'd3, "rp_push3");
    step(0, 1'b1, 1'b0, 1'b0, 2'd0, "rp_push0");
    step(0, 1'b1, 1'b1, 1'b0, 2'd2, "replace");
    step(0, 1'b0, 1'b0, 1'b1, 2'd0, "rp_init");
    step(0, 1'b1, 1'b1, 1'b0, 2'd1, "replace_empty");
    step(0, 1'b0, 1'b0, 1'b1, 2'd0, "rp_init2");

    // Async reset in the middle of a push burst at count=3
    step(0, 1'b1, 1'b0, 1'b0, 2'd2, "burst1");
    step(0, 1'b1, 1'b0, 1'b0, 2'd3, "burst2");
    step(0, 1'b1, 1'b0, 1'b0, 2'd1, "burst3");
    @(negedge clk);
    push_s = 1'b1;
    din_s  = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    mreset();
    check_all("async_reset");
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    mstep(0, 1'b0, 1'b0, 1'b0, 2'd0);
    mstep(1, 1'b0, 1'b0, 1'b0, 2'd0);
    check_all("after_async_reset");
    step(0, 1'b1, 1'b0, 1'b0, 2'd1, "push_after_reset");

    // Random mixed traffic on the small instance
    for (int i = 0; i < 300; i++) begin
      r = 2'($urandom_range(0, 3));
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0), r, "rand_small");
    end

    // Default-size instance: fill, overflow, drain
    for (int i = 0; i < 256; i++) begin
      r = 2'($urandom_range(0, 3));
      step(1, 1'b1, 1'b0, 1'b0, r, "big_fill");
    end
    step(1, 1'b1, 1'b0, 1'b0, 2'd3, "big_overflow");
    for (int i = 0; i < 256; i++) step(1, 1'b0, 1'b1, 1'b0, 2'd0, "big_drain");
    step(1, 1'b0, 1'b1, 1'b0, 2'd0, "big_underflow");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack; next generation of the 2-bit maze-solver stack.
- Generalised in data width and depth.
- Adds occupancy count, combinational peek of top, push+pop replace mode, overflow/underflow error reporting.
- Sits beside the maze controller as the path/move store; usable wherever the system needs LIFO buffering.

Parameters:
WIDTH, 2, data word width in bits (>=1)
DEPTH, 256, number of entries; power of two, >=2
AW, $clog2(DEPTH), derived local parameter; pointer index width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
init  input  1  synchronous clear of stack pointer, output register and error flags
push  input  1  push request, sampled on rising clk
pop  input  1  pop request, sampled on rising clk
data_in  input  WIDTH  word to push
data_out  output  WIDTH  registered; word removed by the most recent successful pop
top  output  WIDTH  combinational peek of current top entry; 0 when empty
count  output  AW+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  push rejected because stack full
underflow  output  1  pop rejected because stack empty

Behaviour:
- One clock domain. Reset is asynchronous and active-high on rst; clock port is clk.
- Reset (async, immediate): sp=0, data_out=0, overflow=0, underflow=0. Storage array is not cleared. While rst is high: top=0, count=0, full=0, empty=1.
- Internal pointer sp is AW+1 bits. count=sp. Entries occupy mem[0..sp-1]. Top entry is mem[sp-1].
- Priority on each rising edge: rst (async) > init > push/pop.
- init=1: sp<=0, data_out<=0, overflow<=0, underflow<=0. push/pop ignored that cycle.
- push only:
  - Not full: mem[sp]<=data_in; sp<=sp+1.
  - Full: no state change; overflow error event.
- pop only:
  - Not empty: data_out<=mem[sp-1]; sp<=sp-1.
  - Empty: data_out holds; underflow error event.
- push and pop together (replace mode):
  - Not empty (including full): data_out<=mem[sp-1]; mem[sp-1]<=data_in; sp unchanged. No error.
  - Empty: pop rejected with underflow event; push executes (mem[0]<=data_in, sp<=1). data_out holds.
- Neither push nor pop: all state holds; error flags behave per the Optional Feature section.
- Latency:
  - Pushed word is visible on top the cycle after the push edge.
  - data_out updates on the pop edge itself (registered, 1-cycle latency from request sample).
- top = (sp==0) ? 0 : mem[sp-1]. Purely combinational from registered state.
- Pointer never wraps. Overflow and underflow never modify sp or memory beyond the rules above.
- Error flags and data_out are registered outputs; full, empty, count and top derive from sp.

Optional Feature:
- Macro: PARAM_STACK_STICKY_ERR_EN
- Defined:
  - overflow/underflow are sticky; set on an error event and held.
  - Cleared only by rst or init.
  - A legal push/pop does not clear them.
- Not defined:
  - overflow/underflow are single-cycle pulses, high for exactly the cycle following the error edge.
  - Cleared on the next edge with no new error of that kind.
- Port list is identical in both builds.

Test Plan:
- Reset/init: WIDTH=2, DEPTH=4; assert rst, release, pulse init -> count=0, empty=1, full=0, data_out=0, top=0, no error flags.
- Ordered LIFO: push 3,0,1,2 -> full=1, count=4, top=2. Then 4 pops -> data_out sequence 2,1,0,3; finally empty=1, count=0.
- Boundary errors:
  - 5th pop when empty -> underflow asserted, data_out holds 3, count stays 0.
  - Fill 4 then push 1 -> overflow asserted, top unchanged.
  - Check pulse vs sticky behaviour in both macro builds; init clears sticky flags.
- Replace mode:
  - With stack [3,0] (top 0), assert push=1, pop=1, data_in=2 in one cycle -> data_out=0, top=2, count=2.
  - Same while full -> no overflow.
  - Same while empty -> underflow, count=1, top=data_in.
- Async reset mid-operation: assert rst between edges during a push burst at count=3 -> outputs go to reset values immediately without a clock edge. After release, push 1 -> count=1, top=1.
- Default params (2x256): push 256 random words, then push 3 -> full=1, overflow raised. Pop 256 -> data_out matches reverse order of pushes; empty=1.
